// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch-side master of the instruction memory. Owns the PC,
//               drives the byte address into a combinational ROM read port,
//               buffers fetched {pc, instr} pairs in a small FIFO and hands
//               them to decode over valid/ready. A single-cycle redirect
//               from execute flushes the buffer and reloads the PC.
//               Optional macro FETCH_BOUND_CHK_EN: fetches at or beyond
//               IMEM_BYTES store a NOP and set a sticky fetch_fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int unsigned       c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [31:0]       c_nop   = 32'h0000_0013;

    logic [31:0]        r_pc;
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic        w_valid;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_full);
    assign w_pop   = w_valid & out_ready;
    // When full, a same-cycle pop frees the head slot which the tail aliases.
    assign w_push  = ~redirect_valid & (~w_full | w_pop);

    // Redirect targets are word aligned by dropping the low bits.
    assign w_unused = ^{redirect_pc[1:0], IMEM_BYTES[0]};

`ifdef FETCH_BOUND_CHK_EN
    logic w_oob;
    logic r_fault;

    assign w_oob       = (r_pc >= IMEM_BYTES);
    assign w_wdata     = w_oob ? c_nop : imem_rdata;
    assign fetch_fault = r_fault;

    // Sticky out-of-range flag, set by any push beyond the memory image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_push && w_oob) begin
            r_fault <= 1'b1;
        end
    end
`else
    logic [31:0] w_unused_nop;

    assign w_unused_nop = c_nop;
    assign w_wdata      = imem_rdata;
    assign fetch_fault  = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign out_valid = w_valid;
    // Outputs read as zero whenever the buffer is empty (including reset).
    assign out_instr = w_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign out_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;

    // PC, pointers and occupancy; redirect flushes and reloads the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Buffer storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pc;
            r_fifo_instr[r_wr_ptr] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A queue-based
//               reference model tracks the PC and buffered {pc, instr}
//               pairs; directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam int          c_depth    = 2;
`ifdef FETCH_BOUND_CHK_EN
    localparam int unsigned c_imem     = 16;
`else
    localparam int unsigned c_imem     = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    instr_fetch_unit #(
        .RESET_PC  (c_reset_pc),
        .FIFO_DEPTH(c_depth),
        .IMEM_BYTES(c_imem)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fetch_fault   (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = c_reset_pc;
        m_fault = 1'b0;
    endtask

    // Compare DUT against the model, then apply one cycle of stimulus.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic [31:0] w;
        chk("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_q.size() != 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (redir) begin
            m_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (rdy && m_q.size() != 0) void'(m_q.pop_front());
            if (m_q.size() < c_depth) begin
                w = rom_word(m_pc);
`ifdef FETCH_BOUND_CHK_EN
                if (m_pc >= c_imem) begin
                    w = 32'h0000_0013;
                    m_fault = 1'b1;
                end
`endif
                m_q.push_back({m_pc, w});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        model_reset();
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_addr", imem_addr, c_reset_pc);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        rst_n = 1'b1;

        // Streaming from reset with decode always ready
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        // Back-pressure fills the buffer, then drains in order
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        // Redirect while full to a misaligned target
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0012);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        // Redirect with a simultaneous pop
        cycle(1'b1, 1'b1, 32'h0000_0040);
        repeat (2) cycle(1'b1, 1'b0, 32'h0);
        // PC wrap-around
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        // Redirect back to zero; any fault stays sticky
        cycle(1'b1, 1'b1, 32'h0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        // Asynchronous reset asserted mid-cycle with a full buffer
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'h0);
        chk("async_addr", imem_addr, c_reset_pc);
        chk("async_fault", {31'b0, fetch_fault}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else
                tgt = $urandom & 32'h3F;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
